tx_mac_control: RTL and testbench

TX_MAC_CONTROL -- requirements
Module: tx_mac_control

---
 rtl/tx_mac_control.sv | 131 +++++++++++++
 tb/tb_tx_mac_control.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tx_mac_control.sv
// tx_mac_control: streams VOQ frames from block memory onto GMII with preamble, double-buffered prefetch and underrun abort
module tx_mac_control #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W = 16,
  parameter int BLOCK_BYTES = 64,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE = 8'h55,
  parameter logic [DATA_WIDTH-1:0] SFD_BYTE = 8'hD5
) (
  input  logic                              switch_clk,
  input  logic                              switch_rst,
  input  logic                              voq_valid_i,
  input  logic [ADDR_W-1:0]                 voq_ptr_i,
  output logic                              voq_ready_o,
  output logic                              mem_start_o,
  output logic                              mem_re_o,
  output logic [ADDR_W-1:0]                 mem_start_addr_o,
  input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_i,
  input  logic                              frame_valid_i,
  input  logic                              frame_end_i,
  output logic                              gmii_tx_clk_o,
  output logic                              gmii_tx_en_o,
  output logic                              gmii_tx_er_o,
  output logic [DATA_WIDTH-1:0]             gmii_tx_data_o
);
  localparam int BW = BLOCK_BYTES*DATA_WIDTH;
  localparam int CW = $clog2(BLOCK_BYTES);
  typedef enum logic [2:0] {IDLE, FETCH, PREAMBLE, SFD, DATA, IFG} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [CW-1:0] bcnt;
  logic [3:0] icnt;
  logic [BW-1:0] act_data, pf_data;
  logic act_v, act_end, pf_v, pf_end, req, last_rx, err;
  logic tick, blk_end, xmit;
  logic [DATA_WIDTH-1:0] cur_byte;
  assign tick = cnt == 2'd3;
  assign blk_end = bcnt == CW'(BLOCK_BYTES-1);
  assign xmit = state == PREAMBLE || state == SFD || state == DATA;
  assign cur_byte = act_data[bcnt*DATA_WIDTH +: DATA_WIDTH];
  assign gmii_tx_clk_o = cnt[1];
  assign voq_ready_o = state == IDLE;
  always_ff @(posedge switch_clk or posedge switch_rst)
    if (switch_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = voq_valid_i ? FETCH : IDLE;
      FETCH:    state_n = tick && act_v ? PREAMBLE : FETCH;
      PREAMBLE: state_n = tick && bcnt == CW'(6) ? SFD : PREAMBLE;
      SFD:      state_n = tick ? DATA : SFD;
      DATA:     state_n = tick && (err || (blk_end && act_end)) ? IFG : DATA;
      IFG:      state_n = tick && icnt == 4'd11 ? IDLE : IFG;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      cnt <= '0;
      bcnt <= '0;
      icnt <= '0;
      act_data <= '0;
      pf_data <= '0;
      {act_v, act_end, pf_v, pf_end, req, last_rx, err} <= '0;
      mem_start_o <= 1'b0;
      mem_re_o <= 1'b0;
      mem_start_addr_o <= '0;
      gmii_tx_en_o <= 1'b0;
      gmii_tx_er_o <= 1'b0;
      gmii_tx_data_o <= '0;
    end else begin
      cnt <= cnt + 2'd1;
      mem_start_o <= 1'b0;
      mem_re_o <= 1'b0;
      if (state == IDLE && voq_valid_i) begin
        mem_start_o <= 1'b1;
        mem_start_addr_o <= voq_ptr_i;
        req <= 1'b1;
        {act_v, pf_v, last_rx, err} <= '0;
        bcnt <= '0;
        icnt <= '0;
      end
      if (xmit && !pf_v && !req && !last_rx) begin
        mem_re_o <= 1'b1;
        req <= 1'b1;
      end
      if (frame_valid_i && req) begin
        req <= 1'b0;
        last_rx <= frame_end_i;
        if (!act_v) {act_data, act_end, act_v} <= {frame_data_i, frame_end_i, 1'b1};
        else {pf_data, pf_end, pf_v} <= {frame_data_i, frame_end_i, 1'b1};
      end
      if (tick) begin
        gmii_tx_en_o <= xmit;
        gmii_tx_er_o <= 1'b0;
        gmii_tx_data_o <= '0;
        case (state)
          PREAMBLE: begin
            gmii_tx_data_o <= PREAMBLE_BYTE;
            bcnt <= bcnt + CW'(1);
          end
          SFD: begin
            gmii_tx_data_o <= SFD_BYTE;
            bcnt <= '0;
          end
          DATA:
            if (err) begin
              gmii_tx_er_o <= 1'b1;
              err <= 1'b0;
            end else begin
              gmii_tx_data_o <= cur_byte;
              bcnt <= blk_end ? '0 : bcnt + CW'(1);
              if (blk_end && !act_end && pf_v) begin
                {act_data, act_end} <= {pf_data, pf_end};
                pf_v <= 1'b0;
              end
              // underrun: drop any in-flight or late block so it cannot leak into the next frame
              if (blk_end && !act_end && !pf_v) begin
                err <= 1'b1;
                req <= 1'b0;
                last_rx <= 1'b1;
                pf_v <= 1'b0;
              end
            end
          IFG: icnt <= icnt + 4'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_mac_control.sv
// tb_tx_mac_control: directed frames against a behavioural block memory, GMII stream checked against hand-built expectations
`timescale 1ns/1ps
module tb_tx_mac_control;
  logic clk = 0, rst = 1;
  logic voq_valid = 0;
  logic [15:0] voq_ptr = 0;
  logic voq_ready, mem_start, mem_re;
  logic [15:0] mem_addr;
  logic [511:0] frame_data = 0;
  logic frame_valid = 0, frame_end = 0;
  logic tx_clk, tx_en, tx_er;
  logic [7:0] tx_data;
  int checks = 0, errors = 0;
  int n_start, n_re, n_er, n_rise, n_bad, min_gap, gap;
  int len, seed, delay;
  bit withhold;
  logic [15:0] addr_seen;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  logic prev_en = 0;
  always #2 clk = ~clk;
  tx_mac_control dut (
    .switch_clk(clk), .switch_rst(rst), .voq_valid_i(voq_valid), .voq_ptr_i(voq_ptr),
    .voq_ready_o(voq_ready), .mem_start_o(mem_start), .mem_re_o(mem_re),
    .mem_start_addr_o(mem_addr), .frame_data_i(frame_data), .frame_valid_i(frame_valid),
    .frame_end_i(frame_end), .gmii_tx_clk_o(tx_clk), .gmii_tx_en_o(tx_en),
    .gmii_tx_er_o(tx_er), .gmii_tx_data_o(tx_data));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] pay(input int i);
    return i < len ? 8'((i + seed) & 255) : 8'h00;
  endfunction
  initial forever begin
    int blk;
    @(negedge clk);
    if (mem_start || mem_re) begin
      if (mem_start) begin
        blk = 0;
        n_start++;
        addr_seen = mem_addr;
      end else begin
        blk++;
        n_re++;
      end
      repeat (withhold && blk > 0 ? 600 : delay) @(negedge clk);
      for (int j = 0; j < 64; j++) frame_data[8*j +: 8] = pay(blk*64 + j);
      frame_end = (blk + 1) * 64 >= len;
      frame_valid = 1;
      @(negedge clk);
      frame_valid = 0;
    end
  end
  initial forever begin
    @(posedge tx_clk);
    #1;
    if (tx_en && !tx_er) rx.push_back(tx_data);
    if (tx_er) n_er++;
    if (!tx_en && (tx_er || tx_data != 0)) n_bad++;
    if (tx_en && !prev_en) begin
      n_rise++;
      if (gap < min_gap) min_gap = gap;
    end
    gap = tx_en ? 0 : gap + 1;
    prev_en = tx_en;
  end
  task automatic clear();
    rx.delete();
    {n_start, n_re, n_er, n_rise, n_bad} = '0;
  endtask
  task automatic send(input logic [15:0] ptr, input int l, input int s);
    len = l;
    seed = s;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < ((l + 63) / 64) * 64; i++) exp_q.push_back(pay(i));
    @(negedge clk);
    voq_ptr = ptr;
    voq_valid = 1;
    @(negedge clk);
    voq_valid = 0;
    for (int i = 0; i < 20000 && !voq_ready; i++) @(negedge clk);
    chk("ready_timeout", 32'(voq_ready), 1);
  endtask
  task automatic cmp_stream(input string tag);
    int bad = 0;
    chk({tag, "_len"}, rx.size(), exp_q.size());
    foreach (exp_q[i]) if (i >= rx.size() || rx[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes"}, bad, 0);
    exp_q.delete();
  endtask
  initial begin
    delay = 1;
    withhold = 0;
    min_gap = 1000;
    gap = 1000;
    repeat (5) @(negedge clk);
    chk("rst_ready", 32'(voq_ready), 1);
    chk("rst_outs", {tx_clk, tx_en, tx_er, tx_data, mem_start, mem_re}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_outs", {tx_en, tx_er, tx_data, mem_start, mem_re}, 0);
    clear();
    send(16'h1000, 64, 0);
    chk("t1_start", n_start, 1);
    chk("t1_addr", 32'(addr_seen), 32'h1000);
    chk("t1_re", n_re, 0);
    cmp_stream("t1");
    chk("t1_er", n_er, 0);
    clear();
    send(16'h2000, 150, 0);
    chk("t2_start", n_start, 1);
    chk("t2_re", n_re, 2);
    cmp_stream("t2");
    chk("t2_rise", n_rise, 1);
    clear();
    min_gap = 1000;
    send(16'h3000, 64, 0);
    send(16'h3100, 64, 8'h80);
    chk("t3_addr", 32'(addr_seen), 32'h3100);
    chk("t3_start", n_start, 2);
    cmp_stream("t3");
    chk("t3_rise", n_rise, 2);
    chk("t3_gap_ge12", 32'(min_gap >= 12), 1);
    clear();
    delay = 2;
    send(16'h4000, 500, 0);
    chk("t4_re", n_re, 7);
    cmp_stream("t4");
    chk("t4_rise", n_rise, 1);
    chk("t4_er", n_er, 0);
    delay = 1;
    clear();
    len = 64;
    seed = 0;
    @(negedge clk);
    voq_valid = 1;
    @(negedge clk);
    voq_valid = 0;
    repeat (60) @(negedge clk);
    chk("mid_en_before", 32'(tx_en), 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_outs", {tx_clk, tx_en, tx_er, tx_data, mem_start, mem_re}, 0);
    chk("mid_rst_ready", {voq_ready, mem_addr}, 17'h10000);
    rst = 0;
    repeat (400) @(negedge clk);
    chk("mid_rst_quiet", 32'(tx_en), 0);
    clear();
    withhold = 1;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    len = 128;
    for (int i = 0; i < 64; i++) exp_q.push_back(pay(i));
    @(negedge clk);
    voq_ptr = 16'h5000;
    voq_valid = 1;
    @(negedge clk);
    voq_valid = 0;
    for (int i = 0; i < 20000 && !voq_ready; i++) @(negedge clk);
    chk("t5_ready", 32'(voq_ready), 1);
    chk("t5_er", n_er, 1);
    cmp_stream("t5");
    repeat (800) @(negedge clk);
    chk("t5_late_ignored", rx.size(), 72);
    chk("t5_idle", {voq_ready, tx_en, 32'(n_bad)}, 34'h200000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
